fft_controller: RTL and testbench
=================================

FFT_CONTROLLER -- requirements
Module: fft_controller

Interface
REQ-001 Parameter BFLY_LATENCY, default 3, legal range 1..8: cycles from a pair's read issue to its write strobe.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  request to run one 1024-point transform; sampled only in IDLE.
REQ-005 i_abort  input  1  synchronous abort; forces IDLE from any state.
REQ-006 o_busy  output  1  high in RUN and DRAIN.
REQ-007 o_done  output  1  one-cycle pulse when the transform completes.
REQ-008 o_agen_en  output  1  read-issue strobe to the address generator enable.
REQ-009 o_stage  output  4  read-side stage index, 0..9.
REQ-010 o_pair  output  9  read-side butterfly pair index, 0..511.
REQ-011 o_wr_valid  output  1  write strobe for the pair issued BFLY_LATENCY cycles earlier.
REQ-012 o_wr_stage  output  4  stage of the pair being written.
REQ-013 o_wr_pair  output  9  pair index being written.
REQ-014 o_result_in_mem1  output  1  bank holding the final result; constant 1 (stage 9 is odd and writes mem1).

Function
REQ-015 States: IDLE, RUN, DRAIN, DONE; state encoding is free.
REQ-016 IDLE: i_start=1 -> RUN with stage=0, pair=0; i_start=0 -> stay.
REQ-017 RUN: o_agen_en=1 every cycle; pair increments by 1 per cycle; pair=511 -> DRAIN next cycle, pair wraps to 0.
REQ-018 DRAIN: o_agen_en=0 for exactly BFLY_LATENCY cycles; then stage<9 -> RUN with stage+1; stage=9 -> DONE.
REQ-019 DONE: o_done=1 for one cycle, o_busy=0, then IDLE unconditionally; i_start is ignored in DONE.
REQ-020 o_stage and o_pair are registered and change only on RUN cycles or transitions; they hold their values in DRAIN.
REQ-021 Write side is a BFLY_LATENCY-deep shift register of {agen_en, stage, pair}; o_wr_valid, o_wr_stage and o_wr_pair are its output.
REQ-022 No overlap between stages: the last write of stage s occurs in the final DRAIN cycle, before the first read of stage s+1.
REQ-023 Timing: with the start-sample cycle as 0, stage s pair p is read at cycle 1+s*(512+BFLY_LATENCY)+p and o_done is high at cycle 1+10*(512+BFLY_LATENCY).
REQ-024 i_start asserted while busy or in DONE is dropped; it is not queued.
REQ-025 i_abort has priority over i_start and all transitions: IDLE next cycle, write pipeline flushed (o_wr_valid=0 next cycle), no o_done.
REQ-026 i_start and i_abort high together in IDLE: remain in IDLE.
REQ-027 Counter arithmetic is unsigned; pair is 9-bit and wraps naturally; stage never exceeds 9.

Reset
REQ-028 i_rst=1 at an edge: state=IDLE, stage=0, pair=0, write pipeline cleared; outputs o_busy, o_done, o_agen_en, o_wr_valid = 0; o_stage, o_pair, o_wr_stage, o_wr_pair = 0; o_result_in_mem1 = 1.
REQ-029 Reset mid-transform has the same effect as abort, with no o_done and no further writes.
REQ-030 i_rst has priority over i_abort and i_start.

Configuration
REQ-031 Macro FFT_CTRL_CYCLE_COUNT_EN defined: add output o_cycle_count (16 bits). It clears on an accepted start, increments every cycle while o_busy=1, holds after done, and is 0 after reset.
REQ-032 Macro FFT_CTRL_CYCLE_COUNT_EN undefined: the port and the counter are absent; all other behaviour is identical.

Verification
REQ-033 Reset, then idle 10 cycles -> every output at its reset value; o_agen_en never asserts.
REQ-034 BFLY_LATENCY=3, pulse i_start -> RUN cycles 1..512 (stage 0, pairs 0..511); DRAIN cycles 513..515; stage 1 pair 0 at cycle 516; o_done at cycle 5151 only; o_cycle_count=5150.
REQ-035 Compare o_wr_valid, o_wr_stage and o_wr_pair against o_agen_en, o_stage and o_pair delayed 3 cycles -> exact match; exactly 5120 write strobes in total.
REQ-036 Pulse i_start at cycles 100 and 5151 of a run -> both ignored; o_done pulses once; IDLE thereafter.
REQ-037 Assert i_abort at stage 4 pair 200 -> next cycle o_busy=0 and o_wr_valid=0, no o_done; a fresh i_start then runs a full transform with correct timing.
REQ-038 Assert i_rst in DRAIN of stage 9 -> all outputs at reset values next cycle; no o_done.

Source files
------------

// File: rtl/fft_controller.sv
// Sequencing controller for a radix-2 1024-point FFT: 10 stages x 512 butterfly pairs,
// with a BFLY_LATENCY-deep write-side pipeline. Optional o_cycle_count via FFT_CTRL_CYCLE_COUNT_EN.
module fft_controller #(
    parameter int unsigned BFLY_LATENCY = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_agen_en,
    output logic [3:0] o_stage,
    output logic [8:0] o_pair,
    output logic       o_wr_valid,
    output logic [3:0] o_wr_stage,
    output logic [8:0] o_wr_pair,
    output logic       o_result_in_mem1
`ifdef FFT_CTRL_CYCLE_COUNT_EN
    ,
    output logic [15:0] o_cycle_count
`endif
);

    localparam int unsigned LAST_TAP = BFLY_LATENCY - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_stage;
    logic [8:0]  r_pair;
    logic [3:0]  r_drain_cnt;
    logic        w_drain_last;
    logic [13:0] r_pipe [BFLY_LATENCY];

    assign w_drain_last = (r_drain_cnt == 4'(LAST_TAP));

    always_comb begin
        w_next    = r_state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_agen_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_RUN;
            end
            S_RUN: begin
                o_busy    = 1'b1;
                o_agen_en = 1'b1;
                if (r_pair == 9'd511) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (w_drain_last) w_next = (r_stage == 4'd9) ? S_DONE : S_RUN;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_stage     <= '0;
            r_pair      <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (i_abort) begin
                r_stage     <= '0;
                r_pair      <= '0;
                r_drain_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_stage <= '0;
                            r_pair  <= '0;
                        end
                    end
                    S_RUN: begin
                        // pair wraps 511 -> 0 on the way into DRAIN
                        r_pair      <= r_pair + 9'd1;
                        r_drain_cnt <= '0;
                    end
                    S_DRAIN: begin
                        if (w_drain_last) begin
                            if (r_stage != 4'd9) r_stage <= r_stage + 4'd1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Write side: read-issue tuple delayed by the butterfly latency; abort flushes it
    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort) begin
            for (int unsigned i = 0; i < BFLY_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {o_agen_en, r_stage, r_pair};
            for (int unsigned i = 1; i < BFLY_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_stage          = r_stage;
    assign o_pair           = r_pair;
    assign o_wr_valid       = r_pipe[LAST_TAP][13];
    assign o_wr_stage       = r_pipe[LAST_TAP][12:9];
    assign o_wr_pair        = r_pipe[LAST_TAP][8:0];
    assign o_result_in_mem1 = 1'b1;

`ifdef FFT_CTRL_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycle_count <= '0;
        end else if (r_state == S_IDLE && i_start && !i_abort) begin
            r_cycle_count <= '0;
        end else if (o_busy) begin
            r_cycle_count <= r_cycle_count + 16'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_fft_controller.sv
// Directed self-checking bench for fft_controller (BFLY_LATENCY=3): reset, full-run timing,
// write-side delay, dropped starts, abort and reset mid-transform.
module tb_fft_controller;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       o_busy, o_done, o_agen_en;
    logic [3:0] o_stage;
    logic [8:0] o_pair;
    logic       o_wr_valid;
    logic [3:0] o_wr_stage;
    logic [8:0] o_wr_pair;
    logic       o_result_in_mem1;
`ifdef FFT_CTRL_CYCLE_COUNT_EN
    logic [15:0] o_cycle_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fft_controller #(.BFLY_LATENCY(3)) u_dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_agen_en        (o_agen_en),
        .o_stage          (o_stage),
        .o_pair           (o_pair),
        .o_wr_valid       (o_wr_valid),
        .o_wr_stage       (o_wr_stage),
        .o_wr_pair        (o_wr_pair),
        .o_result_in_mem1 (o_result_in_mem1)
`ifdef FFT_CTRL_CYCLE_COUNT_EN
        ,
        .o_cycle_count    (o_cycle_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // {busy, done, agen, stage[3:0], pair[8:0]} expected at cycle c of a run (start sampled in cycle 0)
    function automatic logic [15:0] rd_model(input int c);
        int k, s, p;
        if (c >= 1 && c <= 5150) begin
            k = c - 1;
            s = k / 515;
            p = k % 515;
            if (p < 512) return {1'b1, 1'b0, 1'b1, 4'(s), 9'(p)};
            return {1'b1, 1'b0, 1'b0, 4'(s), 9'd0};
        end
        return '0;
    endfunction

    // {wr_valid, wr_stage, wr_pair}: read tuple from three cycles earlier
    function automatic logic [13:0] wr_model(input int c);
        logic [15:0] m;
        m = rd_model(c - 3);
        return m[13:0];
    endfunction

    function automatic logic [12:0] reset_vec();
        return {o_busy, o_done, o_agen_en, o_stage, o_pair, o_wr_valid, o_wr_stage, o_wr_pair} == 0 ? 13'd0 : 13'h1fff;
    endfunction

    task automatic run_transform(input bit stray);
        int strobes = 0;
        int dones = 0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 5160; c++) begin
            if (o_wr_valid) strobes++;
            if (o_done) dones++;
            if (c <= 5150)
                chk("rd", 32'({o_busy, o_done, o_agen_en, o_stage, o_pair}), 32'(rd_model(c)));
            else if (c == 5151)
                chk("done_cyc", 32'({o_busy, o_done, o_agen_en}), 32'b010);
            else
                chk("post_idle", 32'({o_busy, o_done, o_agen_en}), 32'b000);
            if (c <= 5153)
                chk("wr", 32'({o_wr_valid, o_wr_stage, o_wr_pair}), 32'(wr_model(c)));
            else
                chk("wr_idle", 32'(o_wr_valid), 32'd0);
`ifdef FFT_CTRL_CYCLE_COUNT_EN
            if (c == 5151 || c == 5160) chk("cyc_cnt", 32'(o_cycle_count), 32'd5150);
`endif
            i_start = stray && (c == 100 || c == 5151);
            tick();
        end
        i_start = 1'b0;
        chk("strobes", 32'(strobes), 32'd5120);
        chk("done_cnt", 32'(dones), 32'd1);
    endtask

    initial begin
        int dones;
        bit agen_seen;

        // Reset then idle
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        agen_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (o_agen_en) agen_seen = 1'b1;
            tick();
        end
        chk("rst_outs", 32'({o_busy, o_done, o_agen_en, o_stage, o_pair, o_wr_valid, o_wr_stage, o_wr_pair}), 32'd0);
        chk("rst_mem1", 32'(o_result_in_mem1), 32'd1);
        chk("rst_agen", 32'(agen_seen), 32'd0);
`ifdef FFT_CTRL_CYCLE_COUNT_EN
        chk("rst_cnt", 32'(o_cycle_count), 32'd0);
`endif

        // Start together with abort in IDLE: stays idle
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("st_ab_idle", 32'({o_busy, o_agen_en}), 32'd0);
        tick();
        chk("st_ab_idle2", 32'({o_busy, o_agen_en, o_wr_valid}), 32'd0);

        // Full transform with stray starts at cycles 100 and 5151
        run_transform(1'b1);

        // Abort at stage 4 pair 200 (cycle 1 + 4*515 + 200 = 2261)
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 2261; c++) tick();
        chk("ab_pos", 32'({o_agen_en, o_stage, o_pair}), 32'({1'b1, 4'd4, 9'd200}));
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("ab_next", 32'({o_busy, o_done, o_agen_en, o_wr_valid}), 32'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_done || o_wr_valid || o_busy) dones++;
            tick();
        end
        chk("ab_quiet", 32'(dones), 32'd0);

        // Fresh transform after abort
        run_transform(1'b0);

        // Reset in DRAIN of stage 9 (cycle 5149)
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 5149; c++) tick();
        chk("dr9_pos", 32'({o_busy, o_agen_en, o_stage}), 32'({1'b1, 1'b0, 4'd9}));
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("dr9_rst", 32'({o_busy, o_done, o_agen_en, o_stage, o_pair, o_wr_valid, o_wr_stage, o_wr_pair}), 32'd0);
        chk("dr9_mem1", 32'(o_result_in_mem1), 32'd1);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_done || o_wr_valid || o_busy) dones++;
            tick();
        end
        chk("dr9_quiet", 32'(dones), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
